// File: rtl/sram_pkg.sv
// -----------------------------------------------------------------------------
// sram_pkg
// Shared definitions for the SRAM bridge and its downstream driver:
//   - mosi command field positions and widths
//   - bridge FSM state type
//   - mk_mosi(): packs a driver command word from rw / wdata / address
// -----------------------------------------------------------------------------
package sram_pkg;

    localparam int SRAM_AW = 19;   // halfword address width
    localparam int SRAM_DW = 16;   // SRAM data width
    localparam int MOSI_W  = 36;   // packed command width

    // mosi field positions
    localparam int RW_BIT = 35;
    localparam int WD_MSB = 34;
    localparam int WD_LSB = 19;
    localparam int AD_MSB = 18;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LO   = 3'd1,
        ST_GAP  = 3'd2,
        ST_HI   = 3'd3,
        ST_RESP = 3'd4
    } bridge_state_t;

    // Build a driver command word; unused bits stay zero.
    function automatic logic [MOSI_W-1:0] mk_mosi(
        input logic               rw,
        input logic [SRAM_DW-1:0] wdata,
        input logic [AD_MSB:0]    addr
    );
        logic [MOSI_W-1:0] m;
        m                = '0;
        m[RW_BIT]        = rw;
        m[WD_MSB:WD_LSB] = wdata;
        m[AD_MSB:0]      = addr;
        return m;
    endfunction

endpackage

// File: rtl/sram_bridge.sv
// -----------------------------------------------------------------------------
// sram_bridge
// Splits each 32-bit word request from the core memory stage into two 16-bit
// halfword transactions (low half first) on the SRAM driver's cs_n/mosi/miso
// interface, and returns one response per request.
//
// Ports:
//   sck        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   req_valid  in   request present
//   req_ready  out  bridge can accept (high only in IDLE)
//   req_we     in   1 = write word, 0 = read word
//   req_addr   in   byte address; only bits [SRAM_AW:2] are used
//   req_wdata  in   write data
//   rsp_valid  out  one-cycle completion pulse
//   rsp_rdata  out  read word (0 for writes), held until the next response
//   cs_n       out  driver chip select, active low
//   mosi       out  {rw, wdata[15:0], halfword addr[18:0]}; 0 while cs_n high
//   miso       in   registered read data from the driver
// -----------------------------------------------------------------------------
module sram_bridge #(
    parameter int RD_WAIT = 3,
    parameter int WR_HOLD = 2,
    parameter int SRAM_AW = sram_pkg::SRAM_AW
) (
    input  logic                        sck,
    input  logic                        rst,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_we,
    input  logic [31:0]                 req_addr,
    input  logic [31:0]                 req_wdata,
    output logic                        rsp_valid,
    output logic [31:0]                 rsp_rdata,
    output logic                        cs_n,
    output logic [sram_pkg::MOSI_W-1:0] mosi,
    input  logic [sram_pkg::SRAM_DW-1:0] miso
);
    import sram_pkg::*;

    localparam int MAX_N = (RD_WAIT > WR_HOLD) ? RD_WAIT : WR_HOLD;
    localparam int CNT_W = $clog2(MAX_N + 1);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_WAIT - 1);
    localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_HOLD - 1);

    generate
        if (RD_WAIT < 3 || WR_HOLD < 1 || SRAM_AW != AD_MSB + 1) begin : g_param_check
            $error("sram_bridge: illegal RD_WAIT/WR_HOLD/SRAM_AW");
        end
    endgenerate

    bridge_state_t state_r, state_nxt;

    logic                 we_r,       we_nxt;
    logic [SRAM_AW-2:0]   w_r,        w_nxt;
    logic [SRAM_DW-1:0]   wdata_hi_r, wdata_hi_nxt;
    logic [SRAM_DW-1:0]   rd_lo_r,    rd_lo_nxt;
    logic [CNT_W-1:0]     cnt_r,      cnt_nxt;
    logic                 cs_n_r,     cs_n_nxt;
    logic [MOSI_W-1:0]    mosi_r,     mosi_nxt;
    logic                 ready_r,    ready_nxt;
    logic                 rsp_valid_r, rsp_valid_nxt;
    logic [31:0]          rsp_rdata_r, rsp_rdata_nxt;

    logic                 last_s;
    logic                 unused_s;

    // Address bits outside the word index carry no information for the SRAM.
    assign unused_s = ^{req_addr[31:SRAM_AW+1], req_addr[1:0]};

    // The current halfword ends on the N-th edge since cs_n fell.
    assign last_s = we_r ? (cnt_r == WR_LAST) : (cnt_r == RD_LAST);

    // State register.
    always_ff @(posedge sck or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) state_nxt = ST_LO;
                else           state_nxt = ST_IDLE;
            end
            ST_LO: begin
                if (last_s) state_nxt = ST_GAP;
                else        state_nxt = ST_LO;
            end
            ST_GAP:  state_nxt = ST_HI;
            ST_HI: begin
                if (last_s) state_nxt = ST_RESP;
                else        state_nxt = ST_HI;
            end
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Next values of the latched request, counter and all registered outputs.
    always_comb begin
        we_nxt        = we_r;
        w_nxt         = w_r;
        wdata_hi_nxt  = wdata_hi_r;
        rd_lo_nxt     = rd_lo_r;
        cnt_nxt       = cnt_r;
        cs_n_nxt      = cs_n_r;
        mosi_nxt      = mosi_r;
        rsp_valid_nxt = 1'b0;
        rsp_rdata_nxt = rsp_rdata_r;
        ready_nxt     = (state_nxt == ST_IDLE);
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    we_nxt       = req_we;
                    w_nxt        = req_addr[SRAM_AW:2];
                    wdata_hi_nxt = req_wdata[31:16];
                    cnt_nxt      = '0;
                    cs_n_nxt     = 1'b0;
                    // Reads carry a zero data field.
                    mosi_nxt     = mk_mosi(req_we,
                                           req_we ? req_wdata[15:0] : 16'h0000,
                                           {req_addr[SRAM_AW:2], 1'b0});
                end else begin
                    cs_n_nxt = 1'b1;
                    mosi_nxt = '0;
                end
            end
            ST_LO: begin
                if (last_s) begin
                    cs_n_nxt = 1'b1;
                    mosi_nxt = '0;
                    if (!we_r) rd_lo_nxt = miso;
                    else       rd_lo_nxt = rd_lo_r;
                end else begin
                    cnt_nxt = cnt_r + 1'b1;
                end
            end
            ST_GAP: begin
                cs_n_nxt = 1'b0;
                cnt_nxt  = '0;
                mosi_nxt = mk_mosi(we_r, we_r ? wdata_hi_r : 16'h0000, {w_r, 1'b1});
            end
            ST_HI: begin
                if (last_s) begin
                    cs_n_nxt      = 1'b1;
                    mosi_nxt      = '0;
                    rsp_valid_nxt = 1'b1;
                    if (we_r) rsp_rdata_nxt = 32'h0000_0000;
                    else      rsp_rdata_nxt = {miso, rd_lo_r};
                end else begin
                    cnt_nxt = cnt_r + 1'b1;
                end
            end
            ST_RESP: begin
                cs_n_nxt = 1'b1;
                mosi_nxt = '0;
            end
            default: begin
                cs_n_nxt = 1'b1;
                mosi_nxt = '0;
            end
        endcase
    end

    // Datapath and output registers; reset drops any in-flight request.
    always_ff @(posedge sck or posedge rst) begin
        if (rst) begin
            we_r        <= 1'b0;
            w_r         <= '0;
            wdata_hi_r  <= '0;
            rd_lo_r     <= '0;
            cnt_r       <= '0;
            cs_n_r      <= 1'b1;
            mosi_r      <= '0;
            ready_r     <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 32'h0000_0000;
        end else begin
            we_r        <= we_nxt;
            w_r         <= w_nxt;
            wdata_hi_r  <= wdata_hi_nxt;
            rd_lo_r     <= rd_lo_nxt;
            cnt_r       <= cnt_nxt;
            cs_n_r      <= cs_n_nxt;
            mosi_r      <= mosi_nxt;
            ready_r     <= ready_nxt;
            rsp_valid_r <= rsp_valid_nxt;
            rsp_rdata_r <= rsp_rdata_nxt;
        end
    end

    assign req_ready = ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign cs_n      = cs_n_r;
    assign mosi      = mosi_r;

endmodule

// File: tb/tb_sram_bridge.sv
// -----------------------------------------------------------------------------
// tb_sram_bridge
// Two bridges: u_dut0 with default timing, u_dut1 with RD_WAIT = 5. Each has a
// halfword SRAM model on its driver side. Expected cs_n/mosi/rsp timelines and
// read words are computed from a word-level memory model and the timing rules.
// -----------------------------------------------------------------------------
module tb_sram_bridge;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
    } req_t;

    logic        sck = 1'b0;
    logic [1:0]  rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_we;
    logic [1:0]  rsp_valid;
    logic [1:0]  cs_n;
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic [31:0] rsp_rdata [2];
    logic [35:0] mosi      [2];
    logic [15:0] miso      [2];

    int checks   = 0;
    int failures = 0;

    req_t        rq [$];
    logic [31:0] mem_exp [int];   // expected word contents, key = dut*2^20 + word index

    always #5 sck = ~sck;

    sram_bridge #(.RD_WAIT(3), .WR_HOLD(2), .SRAM_AW(19)) u_dut0 (
        .sck(sck), .rst(rst[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
        .cs_n(cs_n[0]), .mosi(mosi[0]), .miso(miso[0])
    );

    sram_bridge #(.RD_WAIT(5), .WR_HOLD(2), .SRAM_AW(19)) u_dut1 (
        .sck(sck), .rst(rst[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
        .cs_n(cs_n[1]), .mosi(mosi[1]), .miso(miso[1])
    );

    // Halfword SRAM behind each bridge: registered read data, write while selected.
    for (genvar g = 0; g < 2; g++) begin : g_sram
        logic [15:0] mem [int];
        always @(posedge sck) begin
            if (cs_n[g] == 1'b0) begin
                if (mosi[g][35])
                    mem[int'(mosi[g][18:0])] = mosi[g][34:19];
                else
                    miso[g] <= mem.exists(int'(mosi[g][18:0])) ? mem[int'(mosi[g][18:0])] : 16'h0000;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int half_len(input int d, input logic we);
        if (we) return 2;
        return (d == 0) ? 3 : 5;
    endfunction

    task automatic drive(input int d, input req_t r);
        req_we[d]    = r.we;
        req_addr[d]  = r.addr;
        req_wdata[d] = r.wd;
        req_valid[d] = 1'b1;
    endtask

    // Issue every queued request to bridge d and check the full timeline.
    // With hold set, req_valid stays high and the next request is presented
    // while the bridge is still busy. Called #1 after a rising edge.
    task automatic run_q(input int d, input bit hold);
        req_t        r;
        logic [17:0] w;
        logic [35:0] lo, hi, em;
        logic        ecs, erv;
        logic [31:0] exp_rd;
        int          n, key, waited;
        bit          first;
        first = 1'b1;
        while (rq.size() > 0) begin
            r = rq.pop_front();
            if (!hold || first) drive(d, r);
            first  = 1'b0;
            waited = 0;
            while (req_ready[d] !== 1'b1 && waited < 50) begin
                @(posedge sck); #1;
                waited++;
            end
            check("accept_ready", {63'd0, req_ready[d]}, 64'd1);
            @(posedge sck); #1;            // accept edge, k = 0
            if (!hold) req_valid[d] = 1'b0;
            w      = r.addr[19:2];
            n      = half_len(d, r.we);
            key    = d * (1 << 20) + int'(w);
            exp_rd = r.we ? 32'h0 : (mem_exp.exists(key) ? mem_exp[key] : 32'h0);
            if (r.we) mem_exp[key] = r.wd;
            lo = {r.we, (r.we ? r.wd[15:0]  : 16'h0000), w, 1'b0};
            hi = {r.we, (r.we ? r.wd[31:16] : 16'h0000), w, 1'b1};
            for (int k = 0; k <= 2 * n + 1; k++) begin
                if (k > 0) begin
                    @(posedge sck); #1;
                end
                if (k < n)            begin ecs = 1'b0; em = lo;    erv = 1'b0; end
                else if (k == n)      begin ecs = 1'b1; em = 36'h0; erv = 1'b0; end
                else if (k <= 2 * n)  begin ecs = 1'b0; em = hi;    erv = 1'b0; end
                else                  begin ecs = 1'b1; em = 36'h0; erv = 1'b1; end
                check("cs_mosi_rsp", {26'd0, cs_n[d], mosi[d], rsp_valid[d]}, {26'd0, ecs, em, erv});
                if (k == 2) begin
                    // Post-accept noise on the request inputs must not leak in.
                    req_we[d]    = 1'($urandom);
                    req_addr[d]  = $urandom;
                    req_wdata[d] = $urandom;
                end
                if (k == 2 * n + 1) begin
                    check("rsp_rdata", {32'd0, rsp_rdata[d]}, {32'd0, exp_rd});
                    if (hold && rq.size() > 0) drive(d, rq[0]);
                    else                       req_valid[d] = 1'b0;
                end
            end
            @(posedge sck); #1;
            check("resp_done", {62'd0, req_ready[d], rsp_valid[d]}, 64'd2);
        end
    endtask

    task automatic push(input logic we, input logic [31:0] addr, input logic [31:0] wd);
        req_t r;
        r.we   = we;
        r.addr = addr;
        r.wd   = wd;
        rq.push_back(r);
    endtask

    logic [17:0] idx_tab [4];

    initial begin
        int          pulses;
        int          waited;
        req_t        r;
        logic [31:0] a;

        idx_tab[0] = 18'h00004; idx_tab[1] = 18'h00005;
        idx_tab[2] = 18'h3FFFC; idx_tab[3] = 18'h3FFFD;

        rst       = 2'b11;
        req_valid = 2'b00;
        req_we    = 2'b00;
        for (int d = 0; d < 2; d++) begin
            req_addr[d]  = 32'h0;
            req_wdata[d] = 32'h0;
        end
        repeat (3) @(posedge sck);
        #1;
        for (int d = 0; d < 2; d++) begin
            check("reset_state", {26'd0, cs_n[d], mosi[d], req_ready[d], rsp_valid[d]},
                  {26'd0, 1'b1, 36'h0, 1'b1, 1'b0});
            check("reset_rdata", {32'd0, rsp_rdata[d]}, 64'd0);
        end
        @(negedge sck);
        rst = 2'b00;
        @(posedge sck); #1;

        // Directed: word write/read, address bits outside [19:2] ignored.
        push(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
        push(1'b0, 32'h0000_0010, 32'h1234_5678);
        push(1'b1, 32'hFFFF_FFF3, 32'hCAFE_F00D);
        push(1'b0, 32'h000F_FFF0, 32'h0);
        push(1'b0, 32'hFFF0_0013, 32'h0);
        run_q(0, 1'b0);

        // Randomized back-to-back traffic with req_valid held high.
        for (int i = 0; i < 10; i++) begin
            a       = $urandom;
            a[19:2] = idx_tab[$urandom_range(0, 3)];
            push(((i % 2) == 0) ? 1'b1 : 1'b0, a, $urandom);
        end
        run_q(0, 1'b1);

        // Reset while the high half of a read is in flight.
        r.we = 1'b0; r.addr = 32'h0000_0010; r.wd = 32'h0;
        drive(0, r);
        waited = 0;
        while (req_ready[0] !== 1'b1 && waited < 50) begin
            @(posedge sck); #1;
            waited++;
        end
        check("rst_accept_ready", {63'd0, req_ready[0]}, 64'd1);
        @(posedge sck); #1;
        req_valid[0] = 1'b0;
        repeat (5) @(posedge sck);
        #1;
        check("rst_pre_hi", {28'd0, cs_n[0], mosi[0][35:19] == 17'h0, mosi[0][18:0]},
              {28'd0, 1'b0, 1'b1, 19'h00009});
        #1;
        rst[0] = 1'b1;
        #1;
        check("rst_async", {26'd0, cs_n[0], mosi[0], rsp_valid[0], req_ready[0]},
              {26'd0, 1'b1, 36'h0, 1'b0, 1'b1});
        @(negedge sck);
        rst[0] = 1'b0;
        pulses = 0;
        repeat (12) begin
            @(posedge sck); #1;
            if (rsp_valid[0]) pulses++;
        end
        check("rst_no_rsp", 64'(pulses), 64'd0);
        check("rst_ready", {63'd0, req_ready[0]}, 64'd1);
        check("rst_rdata", {32'd0, rsp_rdata[0]}, 64'd0);
        push(1'b0, 32'h0000_0010, 32'h0);
        run_q(0, 1'b0);

        // Longer read wait on the second bridge.
        push(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
        push(1'b0, 32'h0000_0010, 32'h0);
        run_q(1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            a       = $urandom;
            a[19:2] = idx_tab[$urandom_range(0, 3)];
            push(1'($urandom), a, $urandom);
        end
        run_q(1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
